program_loader: RTL and testbench

Boot-time loader that sits directly upstream of the CPU's program memory. It accepts a byte stream over a valid/ready handshake (driven by a UART receiver or debug bridge), assembles little-endian 32-bit instruction words, and writes them sequentially into program memory. It holds the CPU core in reset until a complete image has been written, then releases it.

---
 rtl/program_loader_if.sv | 22 ++
 rtl/program_loader.sv | 147 ++++++++++++++
 tb/tb_program_loader.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_if.sv
// Byte-stream input and program-memory write bus of the boot loader.
// The slave side is the loader, the master side is the byte source / memory.
interface program_loader_if #(
  parameter int ADDR_WIDTH = 12
);
  logic [7:0]            byte_in;
  logic                  byte_valid;
  logic                  byte_ready;
  logic                  pm_write_en;
  logic [ADDR_WIDTH-1:0] pm_write_addr;
  logic [31:0]           pm_write_data;

  modport master (
    output byte_in, byte_valid,
    input  byte_ready, pm_write_en, pm_write_addr, pm_write_data
  );

  modport slave (
    input  byte_in, byte_valid,
    output byte_ready, pm_write_en, pm_write_addr, pm_write_data
  );
endinterface

// File: rtl/program_loader.sv
// Boot loader: takes a length-prefixed little-endian byte image, writes 32-bit
// words into program memory and holds the CPU in reset until the image is complete.
module program_loader #(
  parameter int ADDR_WIDTH     = 12,
  parameter int MAX_WORDS      = 1024,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                clk_70_mhz,
  input  logic                rst_n,
  input  logic                start,
  program_loader_if.slave     bus,
  output logic                cpu_rst_n,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [15:0]         words_loaded
);

  localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, LEN_LO, LEN_HI, DATA, DONE, ERR
  } state_t;

  state_t                state_q, state_d;
  logic [15:0]           count_q, count_d;
  logic [1:0]            byte_idx_q, byte_idx_d;
  logic [23:0]           asm_q, asm_d;
  logic [15:0]           words_q, words_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]           wr_data_q, wr_data_d;

  logic loading;
  logic accept;
  logic [15:0] count_full;

  assign loading    = (state_q == LEN_LO) || (state_q == LEN_HI) || (state_q == DATA);
  assign accept     = loading && bus.byte_valid;
  assign count_full = {bus.byte_in, count_q[7:0]};

  always_ff @(posedge clk_70_mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      count_q    <= '0;
      byte_idx_q <= '0;
      asm_q      <= '0;
      words_q    <= '0;
      tmo_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      byte_idx_q <= byte_idx_d;
      asm_q      <= asm_d;
      words_q    <= words_d;
      tmo_q      <= tmo_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    byte_idx_d = byte_idx_q;
    asm_d      = asm_q;
    words_d    = words_q;
    tmo_d      = tmo_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;

    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d    = LEN_LO;
          words_d    = '0;
          byte_idx_d = '0;
          tmo_d      = '0;
        end
      end
      LEN_LO: begin
        if (accept) begin
          count_d[7:0] = bus.byte_in;
          state_d      = LEN_HI;
        end
      end
      LEN_HI: begin
        if (accept) begin
          count_d[15:8] = bus.byte_in;
          if (count_full == 16'd0)
            state_d = DONE;
          else if ({1'b0, count_full} > 17'(MAX_WORDS))
            state_d = ERR;
          else
            state_d = DATA;
        end
      end
      DATA: begin
        if (accept) begin
          byte_idx_d = byte_idx_q + 2'd1;
          case (byte_idx_q)
            2'd0: asm_d[7:0]   = bus.byte_in;
            2'd1: asm_d[15:8]  = bus.byte_in;
            2'd2: asm_d[23:16] = bus.byte_in;
            default: begin
              wr_en_d   = 1'b1;
              wr_data_d = {bus.byte_in, asm_q};
              wr_addr_d = {words_q[ADDR_WIDTH-3:0], 2'b00};
              words_d   = words_q + 16'd1;
              if (words_q + 16'd1 == count_q)
                state_d = DONE;
            end
          endcase
        end
      end
      default: state_d = IDLE;
    endcase

    // Idle-gap watchdog; a partial word is simply abandoned in the assembly register.
    if (loading) begin
      if (accept) begin
        tmo_d = '0;
      end else begin
        tmo_d = tmo_q + 1'b1;
        if (TIMEOUT_CYCLES != 0 && tmo_q == TW'(TIMEOUT_CYCLES - 1))
          state_d = ERR;
      end
    end
  end

  assign bus.byte_ready    = loading;
  assign bus.pm_write_en   = wr_en_q;
  assign bus.pm_write_addr = wr_addr_q;
  assign bus.pm_write_data = wr_data_q;
  assign busy              = loading;
  assign done              = (state_q == DONE);
  assign error             = (state_q == ERR);
  assign cpu_rst_n         = (state_q == DONE);
  assign words_loaded      = words_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: directed images, expected writes queued
// by the stimulus and checked by an independent write monitor.
`timescale 1ns/1ps
module tb_program_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        cpu_rst_n;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  program_loader_if #(.ADDR_WIDTH(12)) bus ();

  program_loader #(
    .ADDR_WIDTH(12),
    .MAX_WORDS(1024),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_70_mhz  (clk),
    .rst_n       (rst_n),
    .start       (start),
    .bus         (bus.slave),
    .cpu_rst_n   (cpu_rst_n),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .words_loaded(words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] addr;
    logic [31:0] data;
    logic        last;
  } wr_t;

  wr_t      exp_q[$];
  wr_t      mon_e;
  int       n_checks = 0;
  int       n_fail   = 0;
  int       cyc      = 0;
  logic [7:0] img [10];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // Write monitor: every pm_write_en pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (bus.pm_write_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, no write expected",
                 bus.pm_write_addr, bus.pm_write_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", {20'b0, bus.pm_write_addr}, {20'b0, mon_e.addr});
        check("wr_data", bus.pm_write_data, mon_e.data);
        check("done_at_write", {31'b0, done}, {31'b0, mon_e.last});
        check("cpu_rst_n_at_write", {31'b0, cpu_rst_n}, {31'b0, mon_e.last});
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "global timeout");
  end

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int waited;
    waited = 0;
    repeat (gap) begin
      @(negedge clk);
      bus.byte_valid = 1'b0;
      bus.byte_in    = 8'($urandom);
    end
    @(negedge clk);
    bus.byte_valid = 1'b1;
    bus.byte_in    = b;
    while (!bus.byte_ready && waited < 32) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.byte_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL byte_ready_wait: ready=0 after %0d cycles, expected 1", waited);
    end
    @(posedge clk);
    #1 bus.byte_valid = 1'b0;
  endtask

  task automatic expect_image();
    exp_q.push_back('{addr: 12'h000, data: 32'h0000_0013, last: 1'b0});
    exp_q.push_back('{addr: 12'h004, data: 32'h0010_0093, last: 1'b1});
  endtask

  task automatic check_status(input string tag, input logic b, input logic d,
                              input logic e, input logic c, input logic [15:0] w);
    check({tag, "_busy"}, {31'b0, busy}, {31'b0, b});
    check({tag, "_done"}, {31'b0, done}, {31'b0, d});
    check({tag, "_error"}, {31'b0, error}, {31'b0, e});
    check({tag, "_cpu_rst_n"}, {31'b0, cpu_rst_n}, {31'b0, c});
    check({tag, "_words"}, {16'b0, words_loaded}, {16'b0, w});
  endtask

  task automatic load_full_image(input int max_gap);
    do_start();
    expect_image();
    for (int i = 0; i < 10; i++)
      send_byte(img[i], (max_gap == 0) ? 0 : $urandom_range(0, max_gap));
  endtask

  int t0;

  initial begin
    img = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    rst_n = 1'b0;
    start = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_in    = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_byte_ready", {31'b0, bus.byte_ready}, 32'd0);
    check("reset_wr_en", {31'b0, bus.pm_write_en}, 32'd0);
    check_status("reset", 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    rst_n = 1'b1;

    // Back-to-back image, one byte per cycle
    do_start();
    check_status("start", 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
    t0 = cyc;
    expect_image();
    for (int i = 0; i < 10; i++) send_byte(img[i], 0);
    check("b2b_cycles", 32'(cyc - t0), 32'd10);
    @(negedge clk);
    check_status("b2b_end", 1'b0, 1'b1, 1'b0, 1'b1, 16'd2);

    // Bytes offered in DONE must be ignored
    repeat (4) begin
      @(negedge clk);
      bus.byte_valid = 1'b1;
      bus.byte_in    = 8'hFF;
    end
    check("done_byte_ready", {31'b0, bus.byte_ready}, 32'd0);
    @(negedge clk);
    bus.byte_valid = 1'b0;
    check_status("done_ignore", 1'b0, 1'b1, 1'b0, 1'b1, 16'd2);

    // Same image with random idle gaps
    load_full_image(3);
    @(negedge clk);
    check_status("gap_end", 1'b0, 1'b1, 1'b0, 1'b1, 16'd2);

    // Oversized image (1025 words)
    do_start();
    check_status("restart", 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
    send_byte(8'h01, 0);
    send_byte(8'h04, 0);
    @(negedge clk);
    check_status("too_big", 1'b0, 1'b0, 1'b1, 1'b0, 16'd0);

    // Zero-length image
    do_start();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    @(negedge clk);
    check_status("zero_len", 1'b0, 1'b1, 1'b0, 1'b1, 16'd0);

    // Timeout after a partial word
    do_start();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      if (k == 16) check("tmo_idle16_error", {31'b0, error}, 32'd0);
      if (k == 17) check("tmo_idle17_error", {31'b0, error}, 32'd1);
    end
    check_status("tmo", 1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
    load_full_image(0);
    @(negedge clk);
    check_status("after_tmo", 1'b0, 1'b1, 1'b0, 1'b1, 16'd2);

    // Asynchronous reset during the first word's write cycle
    do_start();
    for (int i = 0; i < 6; i++) send_byte(img[i], 0);
    #1 rst_n = 1'b0;
    #1;
    check("arst_wr_en", {31'b0, bus.pm_write_en}, 32'd0);
    check("arst_byte_ready", {31'b0, bus.byte_ready}, 32'd0);
    check_status("arst", 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    load_full_image(0);
    @(negedge clk);
    check_status("after_arst", 1'b0, 1'b1, 1'b0, 1'b1, 16'd2);

    repeat (2) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
